// File: rtl/sprite_ram_writer_if.sv
// Pixel-stream handshake and sprite RAM write port shared by the loader
// (master) and sprite_ram_writer (slave).
interface sprite_ram_writer_if #(
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic [IDX_W-1:0]  in_index;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] wr_address;
  logic [IDX_W-1:0]  wr_data;

  modport master (
    output in_valid, in_index,
    input  in_ready, we, wr_address, wr_data
  );

  modport slave (
    input  in_valid, in_index,
    output in_ready, we, wr_address, wr_data
  );
endinterface

// File: rtl/sprite_ram_writer.sv
// Streams palette indices into a row-major sprite RAM (address = row*SPRITE_W + col),
// optionally mirroring each row, with writes held off during the visible region.
module sprite_ram_writer #(
  parameter int SPRITE_W      = 60,
  parameter int SPRITE_H      = 90,
  parameter int ADDR_W        = 13,
  parameter int IDX_W         = 3,
  parameter int GATE_ON_BLANK = 1
) (
  input  logic                vga_clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                mirror,
  input  logic                blank,
  sprite_ram_writer_if.slave  px,
  output logic                busy,
  output logic                done
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H + 1) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SPRITE_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPRITE_W);
  localparam logic [ADDR_W-1:0] MIR_TOP  = ADDR_W'(SPRITE_W - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              mirror_q;
  logic              we_q;
  logic [ADDR_W-1:0] wr_address_q;
  logic [IDX_W-1:0]  wr_data_q;
  logic              busy_q;
  logic              done_q;

  logic              ready_d;
  logic              xfer_d;
  logic              last_col_d;
  logic              last_px_d;
  logic [ADDR_W-1:0] col_ext_d;
  logic [ADDR_W-1:0] col_off_d;
  logic [ADDR_W-1:0] wr_address_d;

  // A start in LOAD takes the cycle for the restart, so nothing is accepted then.
  always_comb begin
    ready_d      = (state_q == LOAD) && !start && !((GATE_ON_BLANK != 0) && blank);
    xfer_d       = px.in_valid && ready_d;
    last_col_d   = (col_q == COL_LAST);
    last_px_d    = last_col_d && (row_q == ROW_LAST);
    col_ext_d    = ADDR_W'(col_q);
    col_off_d    = mirror_q ? (MIR_TOP - col_ext_d) : col_ext_d;
    wr_address_d = row_base_q + col_off_d;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      mirror_q     <= 1'b0;
      we_q         <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            mirror_q   <= mirror;
          end
        end
        LOAD: begin
          if (start) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            mirror_q   <= mirror;
          end else if (xfer_d) begin
            we_q         <= 1'b1;
            wr_address_q <= wr_address_d;
            wr_data_q    <= px.in_index;
            if (last_col_d) begin
              col_q      <= '0;
              row_q      <= row_q + 1'b1;
              row_base_q <= row_base_q + ROW_STEP;
            end else begin
              col_q <= col_q + 1'b1;
            end
            // Final pixel: done, the last write and busy falling share one edge.
            if (last_px_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign px.in_ready   = ready_d;
  assign px.we         = we_q;
  assign px.wr_address = wr_address_q;
  assign px.wr_data    = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
